// File: rtl/mem_requester.sv
// mem_requester: turns a 1-3 byte little-endian CPU read/write into single-byte RAM request/ready accesses.
// Define MEM_REQ_TIMEOUT_EN to abort a byte whose ram_data_ready wait reaches TIMEOUT_CYCLES.
`timescale 1ns/1ps
module mem_requester #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_start,
  input  logic                  cpu_we,
  input  logic [1:0]            cpu_len,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [23:0]           cpu_wdata,
  output logic                  cpu_busy,
  output logic                  cpu_done,
  output logic [23:0]           cpu_rdata,
  output logic                  cpu_err,
  output logic                  ram_req_rdwr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_data_ready
);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;
  state_t state;
  logic lwe;
  logic [1:0] len, idx, nidx;
  logic [ADDR_WIDTH-1:0] base;
  logic [23:0] wdata;
`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
`endif
  always_comb nidx = idx + 2'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lwe <= 1'b0;
      len <= 2'd0;
      idx <= 2'd0;
      base <= '0;
      wdata <= '0;
      cpu_busy <= 1'b0;
      cpu_done <= 1'b0;
      cpu_rdata <= '0;
      cpu_err <= 1'b0;
      ram_req_rdwr <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_data_in <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      cpu_done <= 1'b0;
      case (state)
        IDLE: if (cpu_start) begin
          lwe <= cpu_we;
          len <= (cpu_len == 2'd0) ? 2'd1 : cpu_len;
          base <= cpu_addr;
          wdata <= cpu_wdata;
          idx <= 2'd0;
          cpu_rdata <= '0;
          cpu_busy <= 1'b1;
          cpu_err <= 1'b0;
          ram_req_rdwr <= 1'b1;
          ram_we <= cpu_we;
          ram_addr <= cpu_addr;
          ram_data_in <= cpu_wdata[7:0];
`ifdef MEM_REQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= ISSUE;
        end
        ISSUE: if (ram_data_ready) begin
          if (!lwe) cpu_rdata[{idx, 3'b000} +: 8] <= ram_data_out;
          ram_req_rdwr <= 1'b0;
          ram_we <= 1'b0;
          state <= GAP;
        end
`ifdef MEM_REQ_TIMEOUT_EN
        else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          ram_req_rdwr <= 1'b0;
          ram_we <= 1'b0;
          cpu_done <= 1'b1;
          cpu_err <= 1'b1;
          state <= DONE;
        end else wait_cnt <= wait_cnt + CW'(1);
`endif
        // ready may still be high from the previous byte, so GAP never looks at it
        GAP: if (idx == len - 2'd1) begin
          cpu_done <= 1'b1;
          state <= DONE;
        end else begin
          idx <= nidx;
          ram_req_rdwr <= 1'b1;
          ram_we <= lwe;
          ram_addr <= base + ADDR_WIDTH'(nidx);
          ram_data_in <= wdata[{nidx, 3'b000} +: 8];
`ifdef MEM_REQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= ISSUE;
        end
        DONE: begin
          cpu_busy <= 1'b0;
          cpu_err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: random and directed commands against a byte-array RAM model with a registered-ready responder.
`timescale 1ns/1ps
module tb_mem_requester;
  logic clk = 1'b0, rst = 1'b1, cpu_start = 1'b0, cpu_we = 1'b0;
  logic [1:0] cpu_len = 2'd0;
  logic [15:0] cpu_addr = 16'd0;
  logic [23:0] cpu_wdata = 24'd0;
  logic cpu_busy, cpu_done, cpu_err, ram_req_rdwr, ram_we;
  logic [23:0] cpu_rdata;
  logic [15:0] ram_addr;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out = 8'd0;
  logic ram_data_ready = 1'b0;
  logic [7:0] ram [0:65535];
  logic [7:0] ref_mem [0:65535];
  int checks = 0, errors = 0;
  int stall = 0, stretch = 0, max_lat = 0;
  int wait_left = 0, stretch_left = 0;
  bit pending = 1'b0;
  logic [15:0] addr_q[$];
  logic [7:0] data_q[$];
  logic we_q[$];
  int dones = 0, issue_cycles = 0, unstable = 0, bad_we = 0;
  logic prev_req = 1'b0, h_we = 1'b0;
  logic [15:0] h_addr = 16'd0;
  logic [7:0] h_data = 8'd0;

  mem_requester dut (
    .clk(clk), .rst(rst), .cpu_start(cpu_start), .cpu_we(cpu_we), .cpu_len(cpu_len),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .ram_req_rdwr(ram_req_rdwr), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .ram_data_ready(ram_data_ready)
  );

  always #5 clk = ~clk;

  // responder: random wait, one registered ready pulse, optionally stretched one cycle into GAP
  always @(posedge clk) begin
    if (stretch_left > 0) stretch_left <= stretch_left - 1;
    else if (ram_data_ready) ram_data_ready <= 1'b0;
    else if (!ram_req_rdwr || stall != 0) pending <= 1'b0;
    else if (!pending) begin
      pending <= 1'b1;
      wait_left <= $urandom_range(0, max_lat);
    end else if (wait_left > 0) wait_left <= wait_left - 1;
    else begin
      ram_data_ready <= 1'b1;
      pending <= 1'b0;
      ram_data_out <= ram[ram_addr];
      if (ram_we) ram[ram_addr] <= ram_data_in;
      stretch_left <= stretch;
    end
  end

  always @(negedge clk) begin
    if (ram_req_rdwr && !prev_req) begin
      addr_q.push_back(ram_addr);
      data_q.push_back(ram_data_in);
      we_q.push_back(ram_we);
      h_addr = ram_addr;
      h_data = ram_data_in;
      h_we = ram_we;
    end else if (ram_req_rdwr && (ram_addr !== h_addr || ram_data_in !== h_data || ram_we !== h_we)) unstable++;
    if (ram_we && !ram_req_rdwr) bad_we++;
    if (ram_req_rdwr) issue_cycles++;
    if (cpu_done) dones++;
    prev_req = ram_req_rdwr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    addr_q.delete();
    data_q.delete();
    we_q.delete();
    dones = 0;
    issue_cycles = 0;
    unstable = 0;
    bad_we = 0;
  endtask

  task automatic wait_done(input int limit);
    int cyc = 0;
    while (cpu_done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", cpu_done, 1);
  endtask

  task automatic run_cmd(input logic we, input logic [1:0] len, input logic [15:0] addr,
                         input logic [23:0] wd, input bit poke);
    int leff = (len == 2'd0) ? 1 : int'(len);
    logic [23:0] exp_rd = 24'd0;
    logic [15:0] a;
    int cyc = 0;
    for (int k = 0; k < leff; k++) begin
      a = addr + 16'(k);
      if (we) ref_mem[a] = wd[8*k +: 8];
      else exp_rd[8*k +: 8] = ref_mem[a];
    end
    clear_mon();
    cpu_we = we; cpu_len = len; cpu_addr = addr; cpu_wdata = wd; cpu_start = 1'b1;
    @(negedge clk);
    cpu_start = 1'b0;
    chk("busy_after_start", cpu_busy, 1);
    while (cpu_done !== 1'b1 && cyc < 300) begin
      if (poke && cyc == 2) begin
        cpu_start = 1'b1; cpu_we = ~we; cpu_addr = addr ^ 16'h5555; cpu_wdata = $urandom;
      end else cpu_start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    cpu_start = 1'b0;
    chk("done_seen", cpu_done, 1);
    chk("err_clear", cpu_err, 0);
    chk("busy_at_done", cpu_busy, 1);
    chk("rdata", cpu_rdata, exp_rd);
    @(negedge clk);
    chk("done_one_cycle", cpu_done, 0);
    chk("busy_dropped", cpu_busy, 0);
    repeat (3) @(negedge clk);
    chk("rdata_hold", cpu_rdata, exp_rd);
    chk("n_req", addr_q.size(), leff);
    for (int k = 0; k < leff && k < addr_q.size(); k++) begin
      a = addr + 16'(k);
      chk("addr_seq", addr_q[k], a);
      chk("we_seq", we_q[k], we);
      if (we) begin
        chk("wr_byte", data_q[k], wd[8*k +: 8]);
        chk("ram_wr", ram[a], wd[8*k +: 8]);
      end
    end
    chk("stable", unstable, 0);
    chk("we_only_issue", bad_we, 0);
    chk("done_count", dones, 1);
  endtask

  initial begin
    logic [7:0] v;
    int cyc;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      ram[i] <= v;
      ref_mem[i] = v;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", cpu_busy, 0);
    chk("rst_done", cpu_done, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_req", ram_req_rdwr, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_data_in, 0);
    rst = 1'b0;
    @(negedge clk);

    ram[16'h0010] <= 8'hA5; ref_mem[16'h0010] = 8'hA5;
    @(negedge clk);
    run_cmd(1'b0, 2'd1, 16'h0010, 24'd0, 1'b0);
    chk("single_read_val", cpu_rdata, 24'h0000A5);

    max_lat = 2;
    run_cmd(1'b1, 2'd3, 16'h0100, 24'h123456, 1'b0);
    chk("wr_0100", ram[16'h0100], 8'h56);
    chk("wr_0102", ram[16'h0102], 8'h12);

    ram[16'hFFFF] <= 8'h11; ref_mem[16'hFFFF] = 8'h11;
    ram[16'h0000] <= 8'h22; ref_mem[16'h0000] = 8'h22;
    @(negedge clk);
    run_cmd(1'b0, 2'd2, 16'hFFFF, 24'd0, 1'b0);
    chk("wrap_read_val", cpu_rdata, 24'h002211);

    stretch = 1;
    run_cmd(1'b0, 2'd3, 16'h2000, 24'd0, 1'b1);
    stretch = 0;

    clear_mon();
    cpu_we = 1'b0; cpu_len = 2'd3; cpu_addr = 16'h3000; cpu_start = 1'b1;
    @(negedge clk);
    cpu_start = 1'b0;
    cyc = 0;
    while (addr_q.size() < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("pre_rst_req", ram_req_rdwr, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_req", ram_req_rdwr, 0);
    chk("mid_rst_busy", cpu_busy, 0);
    chk("mid_rst_rdata", cpu_rdata, 0);
    chk("mid_rst_addr", ram_addr, 0);
    repeat (4) @(negedge clk);
    chk("mid_rst_no_done", dones, 0);
    run_cmd(1'b0, 2'd1, 16'h3001, 24'd0, 1'b0);

    clear_mon();
    rst = 1'b1; cpu_start = 1'b1; cpu_len = 2'd1; cpu_addr = 16'h0040;
    @(negedge clk);
    rst = 1'b0; cpu_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start_busy", cpu_busy, 0);
    chk("rst_start_req", addr_q.size(), 0);

`ifdef MEM_REQ_TIMEOUT_EN
    stall = 1;
    clear_mon();
    cpu_we = 1'b0; cpu_len = 2'd2; cpu_addr = 16'h4000; cpu_start = 1'b1;
    @(negedge clk);
    cpu_start = 1'b0;
    wait_done(100);
    chk("to_err", cpu_err, 1);
    chk("to_issue_cycles", issue_cycles, 15);
    chk("to_rdata", cpu_rdata, 0);
    repeat (4) @(negedge clk);
    chk("to_req_low", ram_req_rdwr, 0);
    chk("to_n_req", addr_q.size(), 1);
    chk("to_done_count", dones, 1);
    stall = 0;
    @(negedge clk);
`endif

    for (int n = 0; n < 24; n++) begin
      stretch = $urandom_range(0, 1);
      max_lat = $urandom_range(0, 3);
      run_cmd(1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0) ? 16'hFFFD + 16'($urandom_range(0, 2)) : 16'($urandom),
              24'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
